fifo_wr_arbiter: RTL

//  Round-robin arbiter sharing the single write port of the sync FIFO (FIFO_IF DUT side)

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between producers, the arbiter and the sync FIFO.
// Handshake: req[i] is valid and gnt[i] is ready; a word moves on the edge where both are high.
interface fifo_wr_arbiter_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_pop;
  logic                          fifo_overflow;

  // Environment side: producers plus the FIFO status returning credits.
  modport master (
    output req, req_data, fifo_pop, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, fifo_pop, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-tracked arbiter for the sync FIFO write port.
// Optional per-requester grant counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  fifo_wr_arbiter_if.slave                 bus,
  input  logic                             clr_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  credits,
  output logic                             busy,
  output logic                             err,
  output logic [NUM_REQ*16-1:0]            stat_gnt_cnt,
  output logic [1:0]                       state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_REQ     = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_STALL = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t                 state, state_nx;
  logic [PW-1:0]          rr_ptr, rr_nx, win_idx;
  logic [NUM_REQ-1:0]     gnt_c;
  logic                   found;
  int                     scan_idx;
  logic                   push, any_req, acct_err, fault;
  logic [CW-1:0]          credits_nx;
  logic                   wr_en_q;
  logic [FIFO_WIDTH-1:0]  data_q;

  assign any_req  = |bus.req;
  assign acct_err = bus.fifo_pop && (credits == FULL_CREDITS);
  assign fault    = bus.fifo_overflow || acct_err;

  // Rotating scan starting at rr_ptr; gated by registered state/credits only.
  always_comb begin
    gnt_c    = '0;
    win_idx  = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (!rst && state != ST_ERR && credits != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (!found && bus.req[scan_idx]) begin
          found           = 1'b1;
          gnt_c[scan_idx] = 1'b1;
          win_idx         = PW'(scan_idx);
        end
      end
    end
  end

  assign push  = found;
  assign rr_nx = (win_idx == LAST_REQ) ? '0 : win_idx + PW'(1);

  // A pop seen while all credits are free is bogus; hold the count and flag it.
  always_comb begin
    credits_nx = credits;
    if (!acct_err) begin
      if (push && !bus.fifo_pop)      credits_nx = credits - CW'(1);
      else if (!push && bus.fifo_pop) credits_nx = credits + CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nx = (credits != '0) ? ST_GRANT : ST_STALL;
      end
      ST_GRANT: begin
        if (!any_req)               state_nx = ST_IDLE;
        else if (credits_nx == '0)  state_nx = ST_STALL;
      end
      ST_STALL: begin
        if (!any_req)               state_nx = ST_IDLE;
        else if (credits != '0)     state_nx = ST_GRANT;
      end
      ST_ERR: begin
        // A fresh fault in the clearing cycle keeps us parked here.
        if (clr_err && !fault)      state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (state != ST_ERR && fault) state_nx = ST_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      credits <= FULL_CREDITS;
      err     <= 1'b0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nx;
      credits <= credits_nx;
      err     <= (state_nx == ST_ERR);
      wr_en_q <= push;
      if (push) begin
        data_q <= bus.req_data[win_idx*FIFO_WIDTH +: FIFO_WIDTH];
        rr_ptr <= rr_nx;
      end
    end
  end

  assign bus.gnt          = gnt_c;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign busy             = (state == ST_GRANT);
  assign state_dbg        = state;

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                             cnt <= '0;
      else if (gnt_c[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_gnt_cnt[i*16 +: 16] = cnt;
  end
`else
  assign stat_gnt_cnt = '0;
`endif

endmodule
